// File: rtl/video_timing_detect.sv
// rtl/video_timing_detect.sv - measures incoming sync/blank geometry and locks once stable
// Optional macro VT_DETECT_POLARITY_EN adds sync polarity auto-detect (hs_pol/vs_pol ports).
module video_timing_detect #(
  parameter int LOCK_FRAMES = 2,
  parameter int CW          = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_pix,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          hbl_in,
  input  logic          vbl_in,
  output logic [CW-1:0] hc,
  output logic [CW-1:0] vc,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] h_active,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] v_active,
  output logic [CW-1:0] hs_start,
  output logic [CW-1:0] vs_start,
  output logic          locked,
`ifdef VT_DETECT_POLARITY_EN
  output logic          hs_pol,
  output logic          vs_pol,
`endif
  output logic          lock_lost
);

  localparam logic [CW-1:0] MAX = '1;

  typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_VERIFY, S_LOCKED} state_t;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == MAX) ? v : v + CW'(1);
  endfunction

  logic          hbl_prev_q, hs_prev_q, vs_prev_q, vbl_line_q;
  logic          vs_pend_q, vs_pend_d;
  logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
  logic [CW-1:0] hact_q, hact_d, vact_q, vact_d;
  logic [CW-1:0] h_len_q, h_len_d, h_act_q, h_act_d;
  logic [CW-1:0] hs_meas_q, hs_meas_d, vs_meas_q, vs_meas_d;
  logic          have_line_q, have_line_d;
  logic          line_var_q, line_var_d, frame_bad_q, frame_bad_d;

  state_t        state_q;
  logic [7:0]    match_cnt_q;
  logic [CW-1:0] snap_ht_q, snap_ha_q, snap_vt_q, snap_va_q, snap_hs_q, snap_vs_q;
  logic [CW-1:0] out_ht_q, out_ha_q, out_vt_q, out_va_q, out_hs_q, out_vs_q;
  logic          locked_q, lock_lost_q;

  logic          hs_eff, vs_eff, pol_match;
  logic          ls, fs, hs_rise, vs_rise, sat_now;
  logic [CW-1:0] hc_nx, vc_nx, line_len;
  logic [CW-1:0] f_ht, f_ha, f_vt, f_va;
  logic          line_var_now, frame_ok, snap_take;

`ifdef VT_DETECT_POLARITY_EN
  localparam int BW = 2 * CW + 1;
  localparam logic signed [BW-1:0] BMAX = {1'b0, {(BW-1){1'b1}}};
  localparam logic signed [BW-1:0] BMIN = {1'b1, {(BW-1){1'b0}}};

  logic signed [BW-1:0] hs_bal_q, vs_bal_q;
  logic                 hs_pol_q, vs_pol_q, snap_hpol_q, snap_vpol_q;
  logic                 f_hpol, f_vpol;

  function automatic logic signed [BW-1:0] bal_step(input logic signed [BW-1:0] b, input logic lvl);
    if (lvl && b != BMAX) return b + BW'(1);
    if (!lvl && b != BMIN) return b - BW'(1);
    return b;
  endfunction

  // A level held high for most of the frame means the sync pulse is active-low.
  assign f_hpol    = (hs_bal_q > 0);
  assign f_vpol    = (vs_bal_q > 0);
  assign hs_eff    = hsync_in ^ hs_pol_q;
  assign vs_eff    = vsync_in ^ vs_pol_q;
  assign pol_match = (f_hpol == snap_hpol_q) && (f_vpol == snap_vpol_q);
  assign hs_pol    = hs_pol_q;
  assign vs_pol    = vs_pol_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_bal_q    <= '0;
      vs_bal_q    <= '0;
      hs_pol_q    <= 1'b0;
      vs_pol_q    <= 1'b0;
      snap_hpol_q <= 1'b0;
      snap_vpol_q <= 1'b0;
    end else if (clk_pix) begin
      if (fs) begin
        hs_bal_q <= '0;
        vs_bal_q <= '0;
        hs_pol_q <= f_hpol;
        vs_pol_q <= f_vpol;
        if (snap_take) begin
          snap_hpol_q <= f_hpol;
          snap_vpol_q <= f_vpol;
        end
      end else begin
        hs_bal_q <= bal_step(hs_bal_q, hsync_in);
        vs_bal_q <= bal_step(vs_bal_q, vsync_in);
      end
    end
  end
`else
  assign hs_eff    = hsync_in;
  assign vs_eff    = vsync_in;
  assign pol_match = 1'b1;
`endif

  assign ls       = clk_pix && !hbl_in && hbl_prev_q;
  assign fs       = ls && !vbl_in && vbl_line_q;
  assign hs_rise  = clk_pix && hs_eff && !hs_prev_q;
  assign vs_rise  = clk_pix && vs_eff && !vs_prev_q;
  assign hc_nx    = ls ? '0 : sat_inc(hc_q);
  assign vc_nx    = fs ? '0 : (ls ? sat_inc(vc_q) : vc_q);
  assign sat_now  = clk_pix && (hc_nx == MAX || vc_nx == MAX);
  assign line_len = hc_q + CW'(1);

  // Any line whose geometry differs from its predecessor spoils the frame it ends in.
  assign line_var_now = ls && have_line_q && (line_len != h_len_q || hact_q != h_act_q);

  assign f_ht = line_len;
  assign f_ha = hact_q;
  assign f_vt = vc_q + CW'(1);
  assign f_va = vact_q;

  assign frame_ok = pol_match && !frame_bad_q && !line_var_q && !line_var_now &&
                    f_ht == snap_ht_q && f_ha == snap_ha_q && f_vt == snap_vt_q &&
                    f_va == snap_va_q && hs_meas_q == snap_hs_q && vs_meas_q == snap_vs_q;
  assign snap_take = fs && !sat_now &&
                     (state_q == S_MEASURE || (state_q == S_VERIFY && !frame_ok));

  always_comb begin
    hc_d        = hc_q;
    vc_d        = vc_q;
    hact_d      = hact_q;
    vact_d      = vact_q;
    hs_meas_d   = hs_meas_q;
    vs_meas_d   = vs_meas_q;
    vs_pend_d   = vs_pend_q;
    h_len_d     = h_len_q;
    h_act_d     = h_act_q;
    have_line_d = have_line_q;
    line_var_d  = line_var_q;
    frame_bad_d = frame_bad_q;
    if (clk_pix) begin
      hc_d = hc_nx;
      vc_d = vc_nx;
      if (ls) hact_d = CW'(1);
      else if (!hbl_in) hact_d = sat_inc(hact_q);
      if (fs) vact_d = CW'(1);
      else if (ls && !vbl_in) vact_d = sat_inc(vact_q);
      if (hs_rise) hs_meas_d = hc_nx;
      if (ls) begin
        vs_pend_d   = 1'b0;
        if (vs_pend_q || vs_rise) vs_meas_d = vc_nx;
        h_len_d     = line_len;
        h_act_d     = hact_q;
        have_line_d = 1'b1;
      end else if (vs_rise) begin
        vs_pend_d = 1'b1;
      end
      line_var_d  = fs ? 1'b0 : (line_var_q | line_var_now);
      frame_bad_d = fs ? 1'b0 : (frame_bad_q | sat_now);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hbl_prev_q  <= 1'b0;
      hs_prev_q   <= 1'b0;
      vs_prev_q   <= 1'b0;
      vbl_line_q  <= 1'b0;
      vs_pend_q   <= 1'b0;
      hc_q        <= '0;
      vc_q        <= '0;
      hact_q      <= '0;
      vact_q      <= '0;
      h_len_q     <= '0;
      h_act_q     <= '0;
      hs_meas_q   <= '0;
      vs_meas_q   <= '0;
      have_line_q <= 1'b0;
      line_var_q  <= 1'b0;
      frame_bad_q <= 1'b0;
    end else if (clk_pix) begin
      hbl_prev_q  <= hbl_in;
      hs_prev_q   <= hs_eff;
      vs_prev_q   <= vs_eff;
      if (ls) vbl_line_q <= vbl_in;
      vs_pend_q   <= vs_pend_d;
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      hact_q      <= hact_d;
      vact_q      <= vact_d;
      h_len_q     <= h_len_d;
      h_act_q     <= h_act_d;
      hs_meas_q   <= hs_meas_d;
      vs_meas_q   <= vs_meas_d;
      have_line_q <= have_line_d;
      line_var_q  <= line_var_d;
      frame_bad_q <= frame_bad_d;
    end
  end

  // Saturation means sync is gone, so it aborts the search without waiting for a frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_SEARCH;
      match_cnt_q <= '0;
      snap_ht_q   <= '0;
      snap_ha_q   <= '0;
      snap_vt_q   <= '0;
      snap_va_q   <= '0;
      snap_hs_q   <= '0;
      snap_vs_q   <= '0;
      out_ht_q    <= '0;
      out_ha_q    <= '0;
      out_vt_q    <= '0;
      out_va_q    <= '0;
      out_hs_q    <= '0;
      out_vs_q    <= '0;
      locked_q    <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      lock_lost_q <= 1'b0;
      if (sat_now) begin
        state_q <= S_SEARCH;
        if (locked_q) begin
          locked_q    <= 1'b0;
          lock_lost_q <= 1'b1;
        end
      end else if (fs) begin
        if (snap_take) begin
          snap_ht_q   <= f_ht;
          snap_ha_q   <= f_ha;
          snap_vt_q   <= f_vt;
          snap_va_q   <= f_va;
          snap_hs_q   <= hs_meas_q;
          snap_vs_q   <= vs_meas_q;
          match_cnt_q <= '0;
        end
        case (state_q)
          S_SEARCH:  state_q <= S_MEASURE;
          S_MEASURE: state_q <= S_VERIFY;
          S_VERIFY: begin
            // The snapshot frame itself counts as the first of the identical frames.
            if (frame_ok) begin
              if (int'(match_cnt_q) + 2 >= LOCK_FRAMES) begin
                state_q  <= S_LOCKED;
                locked_q <= 1'b1;
                out_ht_q <= snap_ht_q;
                out_ha_q <= snap_ha_q;
                out_vt_q <= snap_vt_q;
                out_va_q <= snap_va_q;
                out_hs_q <= snap_hs_q;
                out_vs_q <= snap_vs_q;
              end else begin
                match_cnt_q <= match_cnt_q + 8'd1;
              end
            end
          end
          S_LOCKED: begin
            if (!frame_ok) begin
              state_q     <= S_SEARCH;
              locked_q    <= 1'b0;
              lock_lost_q <= 1'b1;
            end
          end
          default: state_q <= S_SEARCH;
        endcase
      end
    end
  end

  assign hc        = hc_q;
  assign vc        = vc_q;
  assign h_total   = out_ht_q;
  assign h_active  = out_ha_q;
  assign v_total   = out_vt_q;
  assign v_active  = out_va_q;
  assign hs_start  = out_hs_q;
  assign vs_start  = out_vs_q;
  assign locked    = locked_q;
  assign lock_lost = lock_lost_q;

endmodule
